// File: rtl/bus_xfer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_xfer_pkg
//  Description : Shared types and constants for the W/A/B register-bank
//                bus transfer controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_xfer_pkg;

    // Default geometry of the register bank
    localparam int DEF_WIDTH = 8;
    localparam int DEF_NSRC  = 4;
    localparam int DEF_NDST  = 4;

    // Width of the optional completed-transfer counter
    localparam int COUNT_W   = 16;

    // Transfer sequencing: accept -> settle bus -> pulse write-enable
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WRITE = 2'd2
    } xfer_state_e;

endpackage : bus_xfer_pkg
`default_nettype wire

// File: rtl/bus_xfer_ctrl_dst_onehot_dec.sv
`default_nettype none
// ============================================================================
//  Module      : dst_onehot_dec
//  Description : Combinational destination decoder. Turns a destination
//                index into an NDST-bit one-hot vector and reports whether
//                the index addresses an existing destination.
//  Revision    : 1.0 - initial release
// ============================================================================
module dst_onehot_dec #(
    parameter int NDST  = 4,
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0] dst_sel_i,
    output logic [NDST-1:0]  onehot_o,
    output logic             in_range_o
);

    // One comparator per destination; an out-of-range index yields all zeros
    generate
        for (genvar i = 0; i < NDST; i++) begin : g_bit
            assign onehot_o[i] = (dst_sel_i == SEL_W'(i));
        end
    endgenerate

    // Index is legal only when it names one of the NDST destinations
    assign in_range_o = (32'(dst_sel_i) < 32'(NDST));

endmodule : dst_onehot_dec
`default_nettype wire

// File: rtl/bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bus_xfer_ctrl
//  Description : Upstream driver of the W/A/B register bank. Accepts one
//                register-transfer request, drives the selected source word
//                onto the registered BusOut, lets it settle for one cycle,
//                then pulses the one-hot destination write-enable for exactly
//                one cycle. Illegal selects set a sticky error flag and walk
//                the sequence without writing.
//  Options     : BUS_XFER_COUNT_EN - adds the 16-bit xfer_count output that
//                counts completed legal transfers (wraps at 0xFFFF).
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_xfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NSRC  = DEF_NSRC,
    parameter int NDST  = DEF_NDST
) (
    input  logic                     Clk,
    input  logic                     rstN,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [$clog2(NSRC)-1:0]  src_sel,
    input  logic [$clog2(NDST)-1:0]  dst_sel,
    input  logic [NSRC*WIDTH-1:0]    src_data,
    output logic [WIDTH-1:0]         BusOut,
    output logic [NDST-1:0]          WEN,
    output logic                     busy,
    output logic                     sel_err
`ifdef BUS_XFER_COUNT_EN
    ,
    output logic [COUNT_W-1:0]       xfer_count
`endif
);

    localparam int SRC_W = $clog2(NSRC);
    localparam int DST_W = $clog2(NDST);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    xfer_state_e       state_q,  state_d;
    logic [WIDTH-1:0]  bus_q,    bus_d;
    logic [NDST-1:0]   onehot_q, onehot_d;   // write-enable pattern held for WRITE
    logic [NDST-1:0]   wen_q,    wen_d;
    logic              err_q,    err_d;
`ifdef BUS_XFER_COUNT_EN
    logic              legal_q,  legal_d;    // current transfer will really write
    logic [COUNT_W-1:0] cnt_q;
`endif

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic              w_accept;
    logic [WIDTH-1:0]  w_src_word;
    logic              w_src_ok;
    logic [NDST-1:0]   w_dst_onehot;
    logic              w_dst_ok;
    logic              w_legal;

    assign w_accept = req_valid && req_ready;
    assign w_src_ok = (32'(src_sel) < 32'(NSRC));
    assign w_legal  = w_src_ok && w_dst_ok;

    // Destination index decoded straight from the request so the write
    // pattern can be captured together with the bus word at acceptance
    dst_onehot_dec #(
        .NDST  (NDST),
        .SEL_W (DST_W)
    ) u_dst_dec (
        .dst_sel_i  (dst_sel),
        .onehot_o   (w_dst_onehot),
        .in_range_o (w_dst_ok)
    );

    // Source word mux; an out-of-range index falls through to zero
    always_comb begin
        w_src_word = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_sel == SRC_W'(i)) begin
                w_src_word = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and register-input logic
    // ------------------------------------------------------------------
    // Walk IDLE -> DRIVE -> WRITE -> IDLE; capture data only on acceptance
    always_comb begin
        state_d  = state_q;
        bus_d    = bus_q;
        onehot_d = onehot_q;
        wen_d    = wen_q;
        err_d    = err_q;
`ifdef BUS_XFER_COUNT_EN
        legal_d  = legal_q;
`endif
        case (state_q)
            IDLE: begin
                wen_d = '0;
                if (w_accept) begin
                    // Illegal requests still run the sequence, but with a
                    // zeroed bus and no write-enable so nothing is written
                    bus_d    = w_legal ? w_src_word   : '0;
                    onehot_d = w_legal ? w_dst_onehot : '0;
                    if (!w_legal) begin
                        err_d = 1'b1;
                    end
`ifdef BUS_XFER_COUNT_EN
                    legal_d  = w_legal;
`endif
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                // Bus has had a full cycle to settle; enable the write
                wen_d   = onehot_q;
                state_d = WRITE;
            end
            WRITE: begin
                // Destination captures BusOut on this edge; drop the enable
                wen_d   = '0;
                state_d = IDLE;
            end
            default: begin
                wen_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State register; asynchronous reset aborts any transfer in flight
    always_ff @(posedge Clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= IDLE;
            bus_q    <= '0;
            onehot_q <= '0;
            wen_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bus_q    <= bus_d;
            onehot_q <= onehot_d;
            wen_q    <= wen_d;
            err_q    <= err_d;
        end
    end

`ifdef BUS_XFER_COUNT_EN
    // Count transfers that actually wrote a destination, on the edge leaving WRITE
    always_ff @(posedge Clk or negedge rstN) begin
        if (!rstN) begin
            legal_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            legal_q <= legal_d;
            if ((state_q == WRITE) && legal_q) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign xfer_count = cnt_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign BusOut    = bus_q;
    assign WEN       = wen_q;
    assign sel_err   = err_q;

endmodule : bus_xfer_ctrl
`default_nettype wire
